// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: FSM state encoding and master indices.
package ram_arb_pkg;

    typedef enum logic {
        S_INIT = 1'b0,
        S_ARB  = 1'b1
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the shared RAM.
interface ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic              m0_req,   m1_req;
    logic              m0_we,    m1_we;
    logic [ADDR_W-1:0] m0_addr,  m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_gnt,   m1_gnt;
    logic              m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  ram_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr
    );

    // Requester and RAM side
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output ram_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr
    );
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way pick: current owner keeps the bus while its burst allowance lasts,
// otherwise a lone requester wins and a tie goes to the master not served last.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic owner_vld,
    input  logic owner,
    input  logic burst_ok,
    output logic gnt0,
    output logic gnt1
);

    logic owner_req;

    assign owner_req = (owner == M0) ? req0 : req1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (owner_vld && burst_ok && owner_req) begin
            if (owner == M0) gnt0 = 1'b1;
            else             gnt1 = 1'b1;
        end else if (req0 && !req1) begin
            gnt0 = 1'b1;
        end else if (req1 && !req0) begin
            gnt1 = 1'b1;
        end else if (req0 && req1) begin
            if (last == M0) gnt1 = 1'b1;
            else            gnt0 = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one dual-port RAM between a CPU (m0) and a loader (m1), one beat per
// cycle with bounded bursts, and sequences a zero-fill sweep of the whole RAM.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int MAX_BURST     = 4,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_start,
    output logic          init_busy,
    ram_arbiter_if.slave  bus
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sweep_addr;
    logic              owner_vld, owner, last;
    logic [BW-1:0]     beat_cnt;
    logic              rvalid0, rvalid1;
    logic              arb_en, gnt0, gnt1, any_gnt, winner;

    assign arb_en  = !rst && (state_q == S_ARB);
    assign any_gnt = gnt0 | gnt1;
    assign winner  = gnt1 ? M1 : M0;

    rr_arb2 u_pick (
        .req0      (bus.m0_req & arb_en),
        .req1      (bus.m1_req & arb_en),
        .last      (last),
        .owner_vld (owner_vld),
        .owner     (owner),
        .burst_ok  (beat_cnt < MAX_B),
        .gnt0      (gnt0),
        .gnt1      (gnt1)
    );

    always_comb begin
        state_d       = state_q;
        bus.ram_we    = 1'b0;
        bus.ram_waddr = '0;
        bus.ram_wdata = '0;
        bus.ram_re    = 1'b0;
        bus.ram_raddr = '0;
        if (!rst) begin
            case (state_q)
                S_INIT: begin
                    bus.ram_we    = 1'b1;
                    bus.ram_waddr = sweep_addr;
                    if (&sweep_addr) state_d = S_ARB;
                end
                S_ARB: begin
                    if (gnt0) begin
                        bus.ram_we    = bus.m0_we;
                        bus.ram_re    = !bus.m0_we;
                        bus.ram_waddr = bus.m0_addr;
                        bus.ram_raddr = bus.m0_addr;
                        bus.ram_wdata = bus.m0_wdata;
                    end else if (gnt1) begin
                        bus.ram_we    = bus.m1_we;
                        bus.ram_re    = !bus.m1_we;
                        bus.ram_waddr = bus.m1_addr;
                        bus.ram_raddr = bus.m1_addr;
                        bus.ram_wdata = bus.m1_wdata;
                    end
                    if (init_start) state_d = S_INIT;
                end
                default: state_d = S_ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT_ON_RESET ? S_INIT : S_ARB;
            sweep_addr <= '0;
            owner_vld  <= 1'b0;
            owner      <= M0;
            beat_cnt   <= '0;
            last       <= M1;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
        end else begin
            state_q <= state_d;
            rvalid0 <= gnt0 & ~bus.m0_we;
            rvalid1 <= gnt1 & ~bus.m1_we;
            if (state_q == S_INIT) begin
                sweep_addr <= sweep_addr + ADDR_W'(1);
                owner_vld  <= 1'b0;
                beat_cnt   <= '0;
            end else if (init_start) begin
                // The grant of this cycle is still served; burst history restarts after the sweep.
                owner_vld <= 1'b0;
                beat_cnt  <= '0;
                if (any_gnt) begin
                    last  <= winner;
                    owner <= winner;
                end
            end else if (any_gnt) begin
                last      <= winner;
                owner     <= winner;
                owner_vld <= 1'b1;
                if (owner_vld && winner == owner)
                    beat_cnt <= (beat_cnt == MAX_B) ? MAX_B : beat_cnt + BW'(1);
                else
                    beat_cnt <= BW'(1);
            end else begin
                owner_vld <= 1'b0;
                beat_cnt  <= '0;
            end
        end
    end

    assign init_busy     = (state_q == S_INIT);
    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rvalid = rvalid0;
    assign bus.m1_rvalid = rvalid1;
    assign bus.m0_rdata  = bus.ram_rdata;
    assign bus.m1_rdata  = bus.ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: behavioural RAM, shadow memory and
// per-master read queues checked whenever rvalid appears.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    logic init_start;
    logic init_busy;

    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .INIT_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .init_start (init_start),
        .init_busy  (init_busy),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem    [DEPTH];
    logic [DW-1:0] shadow [DEPTH];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int checks = 0;
    int errors = 0;
    logic          r_we    [2];
    logic [AW-1:0] r_addr  [2];
    logic [DW-1:0] r_wdata [2];

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
        if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.m0_rvalid === 1'b1) begin
            if (q0.size() == 0) chk("m0_rvalid_unexpected", 32'd1, 32'd0);
            else                chk("m0_rdata", 32'(bus.m0_rdata), 32'(q0.pop_front()));
        end
        if (bus.m1_rvalid === 1'b1) begin
            if (q1.size() == 0) chk("m1_rvalid_unexpected", 32'd1, 32'd0);
            else                chk("m1_rdata", 32'(bus.m1_rdata), 32'(q1.pop_front()));
        end
    end

    task automatic drive(input int m, input logic req, input logic we, input int addr, input int wd);
        r_we[m]    = we;
        r_addr[m]  = AW'(addr);
        r_wdata[m] = DW'(wd);
        if (m == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = AW'(addr); bus.m0_wdata = DW'(wd);
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = AW'(addr); bus.m1_wdata = DW'(wd);
        end
    endtask

    // One arbitration cycle: check grants and the RAM port for the expected winner.
    task automatic cyc(input logic e0, input logic e1, input string tag);
        int m;
        #1;
        chk({tag, "_gnt0"}, 32'(bus.m0_gnt), 32'(e0));
        chk({tag, "_gnt1"}, 32'(bus.m1_gnt), 32'(e1));
        chk({tag, "_we_re_excl"}, 32'(bus.ram_we & bus.ram_re), 32'd0);
        if (e0 || e1) begin
            m = e0 ? 0 : 1;
            if (r_we[m]) begin
                chk({tag, "_ram_we"}, 32'(bus.ram_we), 32'd1);
                chk({tag, "_ram_waddr"}, 32'(bus.ram_waddr), 32'(r_addr[m]));
                chk({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 32'(r_wdata[m]));
                shadow[r_addr[m]] = r_wdata[m];
            end else begin
                chk({tag, "_ram_re"}, 32'(bus.ram_re), 32'd1);
                chk({tag, "_ram_raddr"}, 32'(bus.ram_raddr), 32'(r_addr[m]));
                if (m == 0) q0.push_back(shadow[r_addr[m]]);
                else        q1.push_back(shadow[r_addr[m]]);
            end
        end else begin
            chk({tag, "_idle_we"}, 32'(bus.ram_we), 32'd0);
            chk({tag, "_idle_re"}, 32'(bus.ram_re), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sweep cycles from address 0; init_start pulsed at step pulse_at must be ignored.
    task automatic sweep(input int n, input int pulse_at, input string tag);
        for (int i = 0; i < n; i++) begin
            #1;
            chk({tag, "_busy"}, 32'(init_busy), 32'd1);
            chk({tag, "_ram_we"}, 32'(bus.ram_we), 32'd1);
            chk({tag, "_waddr"}, 32'(bus.ram_waddr), 32'(i));
            chk({tag, "_wdata"}, 32'(bus.ram_wdata), 32'd0);
            chk({tag, "_ram_re"}, 32'(bus.ram_re), 32'd0);
            chk({tag, "_gnt"}, 32'({bus.m0_gnt, bus.m1_gnt}), 32'd0);
            init_start = (i == pulse_at);
            @(posedge clk);
            @(negedge clk);
        end
        init_start = 1'b0;
        if (n == DEPTH)
            for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1'b1, 1'b0, i, 0);
            cyc(1'b1, 1'b0, tag);
        end
        drive(0, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, {tag, "_idle"});
    endtask

    initial begin
        rst = 1'b1;
        init_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = 8'hA5;
            shadow[i] = 8'hA5;
        end
        drive(0, 1'b1, 1'b0, 3, 0);
        drive(1, 1'b1, 1'b0, 4, 0);
        @(negedge clk);
        repeat (2) begin
            #1;
            chk("rst_gnt", 32'({bus.m0_gnt, bus.m1_gnt}), 32'd0);
            chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
            chk("rst_ram_re", 32'(bus.ram_re), 32'd0);
            @(negedge clk);
        end
        chk("rst_rvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'd0);
        chk("rst_busy", 32'(init_busy), 32'd1);
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 0, 0);
        drive(1, 1'b0, 1'b0, 0, 0);

        // 1) sweep after reset, then every address reads zero
        sweep(DEPTH, -1, "t1_sweep");
        chk("t1_busy_done", 32'(init_busy), 32'd0);
        read_all("t1_rd");

        // 2) write then read back-to-back
        drive(0, 1'b1, 1'b1, 5, 'h12);
        cyc(1'b1, 1'b0, "t2_wr");
        drive(0, 1'b1, 1'b0, 5, 0);
        cyc(1'b1, 1'b0, "t2_rd");
        drive(0, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, "t2_idle");

        // 3) one m1 beat so the next tie goes to m0, then sustained contention
        drive(1, 1'b1, 1'b0, 9, 0);
        cyc(1'b0, 1'b1, "t3_pre");
        drive(1, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, "t3_pre_idle");
        drive(0, 1'b1, 1'b0, 5, 0);
        drive(1, 1'b1, 1'b0, 9, 0);
        for (int i = 0; i < 3 * MB; i++) begin
            if (((i / MB) % 2) == 0) cyc(1'b1, 1'b0, "t3_m0");
            else                     cyc(1'b0, 1'b1, "t3_m1");
        end
        drive(0, 1'b0, 1'b0, 0, 0);
        drive(1, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, "t3_idle");

        // 5) init_start in the same cycle as an m1 read grant
        drive(1, 1'b1, 1'b1, 'h20, 'h77);
        cyc(1'b0, 1'b1, "t5_wr");
        drive(1, 1'b1, 1'b0, 'h20, 0);
        init_start = 1'b1;
        cyc(1'b0, 1'b1, "t5_rd");
        init_start = 1'b0;
        drive(1, 1'b0, 1'b0, 0, 0);
        drive(0, 1'b1, 1'b0, 'h20, 0);
        sweep(DEPTH, 10, "t5_sweep");
        cyc(1'b1, 1'b0, "t5_post");
        read_all("t5_rd_all");

        // 6) reset mid-sweep restarts the sweep from zero
        init_start = 1'b1;
        cyc(1'b0, 1'b0, "t6_start");
        init_start = 1'b0;
        sweep(7, -1, "t6_part");
        #1;
        chk("t6_waddr7", 32'(bus.ram_waddr), 32'd7);
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 1, 0);
        drive(1, 1'b1, 1'b0, 2, 0);
        repeat (2) begin
            #1;
            chk("t6_rst_gnt", 32'({bus.m0_gnt, bus.m1_gnt}), 32'd0);
            chk("t6_rst_re", 32'(bus.ram_re), 32'd0);
            chk("t6_rst_we", 32'(bus.ram_we), 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk("t6_rst_rvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'd0);
        end
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 0, 0);
        drive(1, 1'b0, 1'b0, 0, 0);
        sweep(DEPTH, -1, "t6_sweep");

        // 4) fresh tie goes to m0, then m1; later tie goes to !last
        drive(0, 1'b1, 1'b0, 1, 0);
        drive(1, 1'b1, 1'b0, 2, 0);
        cyc(1'b1, 1'b0, "t4_tie1");
        drive(0, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b1, "t4_m1_next");
        drive(1, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, "t4_idle1");
        drive(0, 1'b1, 1'b0, 3, 0);
        cyc(1'b1, 1'b0, "t4_m0_solo");
        drive(0, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, "t4_idle2");
        drive(0, 1'b1, 1'b0, 3, 0);
        drive(1, 1'b1, 1'b0, 4, 0);
        cyc(1'b0, 1'b1, "t4_tie2");
        drive(1, 1'b0, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, "t4_m0_after");
        drive(0, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, "t4_idle3");
        cyc(1'b0, 1'b0, "t4_idle4");

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
